// File: rtl/window_5x3_ctrl.sv
// window_5x3_ctrl: raster sequencer for the 5x3 disparity window register.
// Drives line-buffer writes and window shifts from a valid/ready pixel stream
// and flags the shifts that leave a fully populated interior window.
// Optional build macro: WIN_CTRL_STALL_CNT_EN (source stall cycle counter).
module window_5x3_ctrl #(
   parameter int unsigned COL_W = 11,
   parameter int unsigned ROW_W = 11
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic [COL_W-1:0] width,
   input  logic [ROW_W-1:0] height,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             lb_wr_en,
   output logic [COL_W-1:0] lb_wr_addr,
   output logic             win_clken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ROW_W-1:0] out_row,
   output logic [COL_W-1:0] out_col,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err,
   output logic [31:0]      stall_cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [COL_W-1:0] r_width;
   logic [ROW_W-1:0] r_height;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_out_valid;
   logic [ROW_W-1:0] r_out_row;
   logic [COL_W-1:0] r_out_col;
   logic             r_frame_done;
   logic             r_cfg_err;

   logic w_cfg_ok;
   logic w_start_ok;
   logic w_start_bad;
   logic w_in_ready;
   logic w_accept;
   logic w_col_last;
   logic w_row_last;
   logic w_qual;
   logic w_frame_end;
   logic w_drain;
   logic w_busy;

   // Configuration check and frame-start qualification (only honoured in IDLE)
   assign w_cfg_ok    = (width >= COL_W'(3)) && (height >= ROW_W'(5));
   assign w_start_ok  = (r_state == S_IDLE) && start && w_cfg_ok;
   assign w_start_bad = (r_state == S_IDLE) && start && !w_cfg_ok;

   // Handshake: accept only while streaming and the window is not held by backpressure
   assign w_in_ready  = ((r_state == S_FILL) || (r_state == S_RUN)) &&
                        !(r_out_valid && !out_ready);
   assign w_accept    = in_valid && w_in_ready;

   // Raster position decode against the latched frame size
   assign w_col_last  = (r_col == (r_width - COL_W'(1)));
   assign w_row_last  = (r_row == (r_height - ROW_W'(1)));
   assign w_qual      = w_accept && (r_row >= ROW_W'(4)) && (r_col >= COL_W'(2));
   assign w_frame_end = w_accept && w_col_last && w_row_last;

   // DONE may retire once the last window is gone or is being consumed now
   assign w_drain     = (r_state == S_DONE) && (!r_out_valid || out_ready);
   assign w_busy      = (r_state != S_IDLE);

   // State register
   always_ff @(posedge clock) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_next = S_FILL;
            end
         end
         S_FILL: begin
            if (w_frame_end) begin
               w_next = S_DONE;
            end else if (w_qual) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_frame_end) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (w_drain) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Frame config, raster counters, window flag/coordinates and status pulses
   always_ff @(posedge clock) begin
      if (rst) begin
         r_width      <= '0;
         r_height     <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_out_valid  <= 1'b0;
         r_out_row    <= '0;
         r_out_col    <= '0;
         r_frame_done <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_cfg_err    <= w_start_bad;
         r_frame_done <= w_drain;

         if (w_start_ok) begin
            r_width  <= width;
            r_height <= height;
            r_col    <= '0;
            r_row    <= '0;
         end else if (w_accept) begin
            if (w_col_last) begin
               r_col <= '0;
               // Row stays at height-1 after the final pixel
               if (!w_row_last) begin
                  r_row <= r_row + ROW_W'(1);
               end
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end

         // A qualifying shift re-arms the flag even while the previous window is consumed
         if (w_qual) begin
            r_out_valid <= 1'b1;
            r_out_row   <= r_row - ROW_W'(2);
            r_out_col   <= r_col - COL_W'(1);
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef WIN_CTRL_STALL_CNT_EN
   localparam int unsigned CNT_W = 32;
   logic [CNT_W-1:0] r_stall;

   // Saturating count of cycles where the source offered a pixel that was refused
   always_ff @(posedge clock) begin
      if (rst) begin
         r_stall <= '0;
      end else if (w_start_ok) begin
         r_stall <= '0;
      end else if (w_busy && in_valid && !w_in_ready && (r_stall != '1)) begin
         r_stall <= r_stall + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall;
`else
   assign stall_cycles = '0;
`endif

   assign in_ready   = w_in_ready;
   assign lb_wr_en   = w_accept;
   assign win_clken  = w_accept;
   assign lb_wr_addr = r_col;
   assign out_valid  = r_out_valid;
   assign out_row    = r_out_row;
   assign out_col    = r_out_col;
   assign busy       = w_busy;
   assign frame_done = r_frame_done;
   assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_window_5x3_ctrl.sv
// Directed self-checking bench for window_5x3_ctrl.
module tb_window_5x3_ctrl;

   localparam int unsigned COL_W = 11;
   localparam int unsigned ROW_W = 11;

`ifdef WIN_CTRL_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   typedef struct {
      int r;
      int c;
   } win_t;

   logic             clock;
   logic             rst;
   logic             start;
   logic [COL_W-1:0] width;
   logic [ROW_W-1:0] height;
   logic             in_valid;
   logic             in_ready;
   logic             lb_wr_en;
   logic [COL_W-1:0] lb_wr_addr;
   logic             win_clken;
   logic             out_valid;
   logic             out_ready;
   logic [ROW_W-1:0] out_row;
   logic [COL_W-1:0] out_col;
   logic             busy;
   logic             frame_done;
   logic             cfg_err;
   logic [31:0]      stall_cycles;

   int checks = 0;
   int errors = 0;

   window_5x3_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
      .clock        (clock),
      .rst          (rst),
      .start        (start),
      .width        (width),
      .height       (height),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .lb_wr_en     (lb_wr_en),
      .lb_wr_addr   (lb_wr_addr),
      .win_clken    (win_clken),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_col      (out_col),
      .busy         (busy),
      .frame_done   (frame_done),
      .cfg_err      (cfg_err),
      .stall_cycles (stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input int w, input int h);
      start  = 1'b1;
      width  = COL_W'(w);
      height = ROW_W'(h);
      tick();
      start  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   in_ready,     0);
      chk({tag, "_lb_wr_en"},   lb_wr_en,     0);
      chk({tag, "_win_clken"},  win_clken,    0);
      chk({tag, "_out_valid"},  out_valid,    0);
      chk({tag, "_out_row"},    out_row,      0);
      chk({tag, "_out_col"},    out_col,      0);
      chk({tag, "_busy"},       busy,         0);
      chk({tag, "_frame_done"}, frame_done,   0);
      chk({tag, "_cfg_err"},    cfg_err,      0);
      chk({tag, "_stall"},      stall_cycles, 0);
   endtask

   // Stream one frame with continuous in_valid; optional first-window stall,
   // ignored mid-frame start, or reset abort (returns with rst held high).
   task automatic run_frame(input string tag, input int w, input int exp_acc, input int exp_win,
                            input int exp_first, input int stall_len, input int start_at,
                            input int abort_at);
      int   n_acc, n_win, first_at, last_win_cyc, done_cyc, stall_left, m_col, m_row;
      bit   done_seen, first_seen, was_stalled, start_done;
      win_t q[$];
      win_t e;
      n_acc = 0; n_win = 0; first_at = -1; last_win_cyc = -100; done_cyc = -1;
      stall_left = stall_len; m_col = 0; m_row = 0;
      done_seen = 0; first_seen = 0; was_stalled = 0; start_done = 0;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
         out_ready = 1'b1;
         start     = 1'b0;
         if (out_valid && n_win == 0 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end
         if (start_at >= 0 && n_acc == start_at && !start_done) begin
            start = 1'b1; width = COL_W'(3); height = ROW_W'(5);
            start_done = 1;
         end
         if (abort_at >= 0 && n_acc == abort_at) begin
            rst = 1'b1;
            return;
         end
         #1;
         if (cyc == 0) chk({tag, "_first_cycle_ready"}, in_ready, 1);
         if (!out_ready && out_valid) begin
            chk({tag, "_stall_in_ready"},  in_ready,  0);
            chk({tag, "_stall_win_clken"}, win_clken, 0);
            chk({tag, "_stall_row"},       out_row,   2);
            chk({tag, "_stall_col"},       out_col,   1);
            was_stalled = 1;
         end else if (was_stalled) begin
            was_stalled = 0;
            chk({tag, "_stall_cycles"}, stall_cycles, STALL_EN ? stall_len : 0);
            chk({tag, "_resume_ready"}, in_ready, 1);
         end
         if (out_valid && !first_seen) begin
            first_seen = 1;
            first_at   = n_acc;
            chk({tag, "_first_row"}, out_row, 2);
            chk({tag, "_first_col"}, out_col, 1);
         end
         if (frame_done) begin
            done_seen = 1;
            done_cyc  = cyc;
            chk({tag, "_done_busy"},     busy,     0);
            chk({tag, "_done_in_ready"}, in_ready, 0);
         end
         if (out_valid && out_ready) begin
            n_win++;
            last_win_cyc = cyc;
            if (q.size() > 0) begin
               e = q.pop_front();
               chk({tag, "_win_row"}, out_row, e.r);
               chk({tag, "_win_col"}, out_col, e.c);
            end
         end
         if (lb_wr_en) begin
            chk({tag, "_wr_addr"},   lb_wr_addr, m_col);
            chk({tag, "_win_clken"}, win_clken,  1);
            if (m_row >= 4 && m_col >= 2) q.push_back('{m_row - 2, m_col - 1});
            n_acc++;
            if (m_col == w - 1) begin
               m_col = 0;
               m_row++;
            end else begin
               m_col++;
            end
         end
         tick();
      end
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_accepts"},     n_acc,     exp_acc);
      chk({tag, "_windows"},     n_win,     exp_win);
      chk({tag, "_first_at"},    first_at,  exp_first);
      chk({tag, "_done_seen"},   done_seen, 1);
      chk({tag, "_done_delay"},  done_cyc - last_win_cyc, 1);
      chk({tag, "_queue_empty"}, q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; width = '0; height = '0;
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Rejected configuration: narrow width, then short height
      start = 1'b1; width = COL_W'(2); height = ROW_W'(10); in_valid = 1'b1;
      #1;
      chk("cfg_err_ready_now", in_ready, 0);
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      chk("cfg_err_ready", in_ready, 0);
      tick();
      chk("cfg_err_clear", cfg_err, 0);
      chk("cfg_err_busy2", busy, 0);
      start = 1'b1; width = COL_W'(8); height = ROW_W'(4);
      tick();
      start = 1'b0;
      chk("cfg_err_h4", cfg_err, 1);
      chk("cfg_err_h4_busy", busy, 0);
      in_valid = 1'b0;
      tick();

      // Nominal 8x6 frame
      do_start(8, 6);
      chk("start_busy", busy, 1);
      run_frame("f8x6", 8, 48, 12, 35, 0, -1, -1);
      tick();

      // 8x6 frame with five-cycle backpressure on the first window
      do_start(8, 6);
      run_frame("stall", 8, 48, 12, 35, 5, -1, -1);
      tick();

      // Start pulsed mid-frame is ignored; counter cleared by the accepted start
      do_start(8, 6);
      chk("restart_stall_clr", stall_cycles, 0);
      run_frame("ign_start", 8, 48, 12, 35, 0, 40, -1);
      tick();

      // Reset at pixel 20, then a clean frame
      do_start(8, 6);
      run_frame("abort", 8, 0, 0, 0, 0, -1, 20);
      tick();
      chk_reset_outputs("midrst");
      rst = 1'b0; in_valid = 1'b0;
      tick();
      do_start(8, 6);
      run_frame("post_rst", 8, 48, 12, 35, 0, -1, -1);
      tick();

      // Minimum frame
      do_start(3, 5);
      run_frame("f3x5", 3, 15, 1, 15, 0, -1, -1);
      tick();
      chk("end_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_5x3_ctrl.md
# window_5x3_ctrl

Sequencer for the 5x3 disparity-map window register. It accepts a raster pixel stream with a valid/ready handshake and drives the line-buffer write strobe/address and the window shift enable (`win_clken`). It tracks row/column position and flags exactly those shifts that leave a fully populated interior window. It sits between the pixel source and the line buffers + 5x3 window, and presents windows to the downstream cost stage with backpressure.

## Interface
Parameters:
- `COL_W`, 11: column counter / width port bits (max width 2047)
- `ROW_W`, 11: row counter / height port bits

Ports:
- `clock`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  one-cycle frame start request
- `width`  in  COL_W  image width in pixels, sampled on accepted `start`
- `height`  in  ROW_W  image height in rows, sampled on accepted `start`
- `in_valid`  in  1  source pixel valid
- `in_ready`  out  1  controller can accept a pixel this cycle
- `lb_wr_en`  out  1  line-buffer write/shift strobe (= accept)
- `lb_wr_addr`  out  COL_W  column of the accepted pixel
- `win_clken`  out  1  window shift enable (= accept)
- `out_valid`  out  1  window register holds a valid interior window
- `out_ready`  in  1  downstream consumed window
- `out_row`  out  ROW_W  centre row of presented window
- `out_col`  out  COL_W  centre column of presented window
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse at end of frame
- `cfg_err`  out  1  one-cycle pulse, rejected configuration
- `stall_cycles`  out  32  source stall counter (see Configuration)

## Operation
- States: IDLE, FILL, RUN, DONE. Reset -> IDLE.
- IDLE: `start` with `width`>=3 and `height`>=5 latches both, clears col/row to 0 -> FILL. `start` with `width`<3 or `height`<5: stay IDLE, pulse `cfg_err`. `start` outside IDLE is ignored.
- accept = `in_valid` & `in_ready`; `in_ready` = (FILL|RUN) & !(`out_valid` & !`out_ready`).
- `lb_wr_en` and `win_clken` are combinational copies of accept; `lb_wr_addr` = current col.
- On accept: col increments; at col = width-1, col wraps to 0 and row increments.
- Accept of pixel (r,c) with r>=4 and c>=2 sets `out_valid` next cycle, with `out_row`=r-2, `out_col`=c-1. The first such accept moves FILL -> RUN.
- `out_valid` clears on `out_ready` unless a new qualifying accept occurs in the same cycle, in which case it stays high with new coordinates.
- Accept of (height-1, width-1) -> DONE; `in_ready` low from then on.
- DONE: once `out_valid` is low (or handshakes this cycle), pulse `frame_done` for one cycle and go to IDLE. `busy` = FILL|RUN|DONE.
- Windows whose centre lies in border rows 0,1,H-2,H-1 or border columns 0,W-1 are never flagged.
- Windows per frame = (height-4)*(width-2).

## Timing
- Reset values: `in_ready`=0, `lb_wr_en`=0, `win_clken`=0, `out_valid`=0, `out_row`=0, `out_col`=0, `busy`=0, `frame_done`=0, `cfg_err`=0, `stall_cycles`=0.
- `start` to first possible accept: 1 cycle (FILL entered on the next edge).
- Accept-to-`out_valid` latency: 1 cycle, matching the window register update on the same edge.
- Throughput: 1 pixel/cycle while `out_ready`=1. When `out_ready`=0 with `out_valid`=1, `in_ready` drops combinationally and the window holds.
- `rst` mid-frame: all state returns to reset values on that edge; no `frame_done`. Line-buffer contents are stale and the next frame re-runs FILL.
- Row/col are never incremented past height-1/width-1. Counters use latched configuration only.

## Configuration
- `WIN_CTRL_STALL_CNT_EN` defined:
  - `stall_cycles` counts cycles with `busy` & `in_valid` & !`in_ready`.
  - Cleared on accepted `start` and on `rst`; saturates at 2^32-1.
- Not defined: `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- width=8, height=6, `out_ready`=1, continuous `in_valid`: 48 accepts; first `out_valid` the cycle after the 35th accept, with (row 2, col 1); 12 windows total; `frame_done` 1 cycle after the last window.
- Same frame, `out_ready` held 0 for 5 cycles at the first window: `in_ready`=0 for those 5 cycles, `win_clken`=0, coordinates stable; with macro defined, `stall_cycles`=5.
- `start` with width=2, height=10: `cfg_err` pulses once, `busy` stays 0, `in_ready` stays 0.
- `rst` asserted at pixel 20 of an 8x6 frame: next cycle all outputs at reset values. A new `start` then yields exactly 12 windows.
- `start` pulsed during RUN: ignored, counters unchanged, frame completes normally.
- width=3, height=5 (minimum): exactly 1 window, at (2,1), on the cycle after the 15th accept.
